// File: rtl/sfu_pkg.sv
// Shared types and saturating arithmetic for the SFU accumulator row.
package sfu_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  localparam int SAT_W = 64;

  // Operands must already lie inside the obw-bit signed range, so the raw sum never overflows SAT_W.
  function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                      input logic signed [SAT_W-1:0] b,
                                                      input int obw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] s;
    hi = (64'sd1 <<< (obw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    s  = a + b;
    if (s > hi)      sat_add = hi;
    else if (s < lo) sat_add = lo;
    else             sat_add = s;
  endfunction

endpackage

// File: rtl/sfu_acc_col.sv
// One column's accumulator memory with saturating read-modify-write.
// SFU_RELU_EN: when defined, the drain output is clamped to max(acc,0); stored values are unchanged.
module sfu_acc_col
  import sfu_pkg::*;
#(
  parameter int BW      = 16,
  parameter int OBW     = 20,
  parameter int NIJ_MAX = 36,
  localparam int AW     = $clog2(NIJ_MAX)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic                  first_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic signed [BW-1:0]  din_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic signed [OBW-1:0] dout_o
);

  logic signed [OBW-1:0] mem_q [NIJ_MAX];
  logic signed [OBW-1:0] wr_d;
  logic signed [OBW-1:0] rd_val;

  // First pass overwrites, so the memory needs no reset.
  always_comb begin
    wr_d = OBW'(sat_add(SAT_W'(mem_q[wr_addr_i]), SAT_W'(din_i), OBW));
    if (first_i) wr_d = OBW'(din_i);
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_d;
  end

  assign rd_val = mem_q[rd_addr_i];

`ifdef SFU_RELU_EN
  assign dout_o = rd_val[OBW-1] ? '0 : rd_val;
`else
  assign dout_o = rd_val;
`endif

endmodule

// File: rtl/sfu_row_acc.sv
// Row of COL SFUs accumulating output-stationary psums over kij passes, then draining one beat per nij.
// SFU_RELU_EN: when defined, drained sums are clamped at zero per column.
module sfu_row_acc
  import sfu_pkg::*;
#(
  parameter int COL      = 8,
  parameter int BW       = 16,
  parameter int OBW      = 20,
  parameter int KIJ_MAX  = 9,
  parameter int NIJ_MAX  = 36,
  localparam int KW      = $clog2(KIJ_MAX + 1),
  localparam int NW      = $clog2(NIJ_MAX + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [KW-1:0]      cfg_kij,
  input  logic [NW-1:0]      cfg_nij,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COL*BW-1:0]  in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COL*OBW-1:0] out,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int AW = $clog2(NIJ_MAX);

  state_e        state_q, state_d;
  logic [KW-1:0] kij_q, kij_d, cfg_kij_q, cfg_kij_d;
  logic [NW-1:0] nij_q, nij_d, rd_q, rd_d, cfg_nij_q, cfg_nij_d;
  logic          done_q, done_d;
  logic          cfg_ok, wr_en, nij_end, kij_end, rd_end;

  assign cfg_ok  = (cfg_kij != '0) && (cfg_kij <= KW'(KIJ_MAX)) &&
                   (cfg_nij != '0) && (cfg_nij <= NW'(NIJ_MAX));
  assign nij_end = (nij_q == cfg_nij_q - NW'(1));
  assign kij_end = (kij_q == cfg_kij_q - KW'(1));
  assign rd_end  = (rd_q == cfg_nij_q - NW'(1));

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid && rd_end;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign wr_en     = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      kij_q     <= '0;
      nij_q     <= '0;
      rd_q      <= '0;
      cfg_kij_q <= '0;
      cfg_nij_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kij_q     <= kij_d;
      nij_q     <= nij_d;
      rd_q      <= rd_d;
      cfg_kij_q <= cfg_kij_d;
      cfg_nij_q <= cfg_nij_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kij_d     = kij_q;
    nij_d     = nij_q;
    rd_d      = rd_q;
    cfg_kij_d = cfg_kij_q;
    cfg_nij_d = cfg_nij_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && cfg_ok) begin
          state_d   = ACCUM;
          cfg_kij_d = cfg_kij;
          cfg_nij_d = cfg_nij;
          kij_d     = '0;
          nij_d     = '0;
          rd_d      = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (nij_end) begin
            nij_d = '0;
            if (kij_end) begin
              kij_d   = '0;
              state_d = DRAIN;
            end else begin
              kij_d = kij_q + KW'(1);
            end
          end else begin
            nij_d = nij_q + NW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_end) begin
            rd_d    = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rd_d = rd_q + NW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar j = 0; j < COL; j++) begin : g_col
    logic signed [OBW-1:0] col_dout;

    sfu_acc_col #(
      .BW      (BW),
      .OBW     (OBW),
      .NIJ_MAX (NIJ_MAX)
    ) u_col (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .first_i   (kij_q == '0),
      .wr_addr_i (nij_q[AW-1:0]),
      .din_i     (in[j*BW +: BW]),
      .rd_addr_i (rd_q[AW-1:0]),
      .dout_o    (col_dout)
    );

    assign out[j*OBW +: OBW] = out_valid ? col_dout : '0;
  end

endmodule

// File: tb/tb_sfu_row_acc.sv
// Directed bench for sfu_row_acc: OBW=20 instance plus an OBW=17 instance sharing all inputs.
module tb_sfu_row_acc;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   cfg_kij = '0;
  logic [5:0]   cfg_nij = '0;
  logic         in_valid = 1'b0;
  logic [127:0] in_v = '0;
  logic         out_ready = 1'b0;

  logic         in_ready1, out_valid1, out_last1, busy1, done1;
  logic [159:0] out1;
  logic         in_ready2, out_valid2, out_last2, busy2, done2;
  logic [135:0] out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sfu_row_acc #(.COL(8), .BW(16), .OBW(20), .KIJ_MAX(9), .NIJ_MAX(36)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_kij(cfg_kij), .cfg_nij(cfg_nij),
    .in_valid(in_valid), .in_ready(in_ready1), .in(in_v), .out_valid(out_valid1),
    .out_ready(out_ready), .out(out1), .out_last(out_last1), .busy(busy1), .done(done1));

  sfu_row_acc #(.COL(8), .BW(16), .OBW(17), .KIJ_MAX(9), .NIJ_MAX(36)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_kij(cfg_kij), .cfg_nij(cfg_nij),
    .in_valid(in_valid), .in_ready(in_ready2), .in(in_v), .out_valid(out_valid2),
    .out_ready(out_ready), .out(out2), .out_last(out_last2), .busy(busy2), .done(done2));

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input beat for a stimulus mode: 0 n+j, 1 all +1, 2 all -3, 3 +max/-min, 4 all n.
  function automatic logic [127:0] beat(input int mode, input int n);
    logic [127:0] r;
    int v;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      case (mode)
        0:       v = n + j;
        1:       v = 1;
        2:       v = -3;
        3:       v = (n == 0) ? 32767 : -32768;
        default: v = n;
      endcase
      r[j*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  // Hand-derived expected sums; mode 3 is always run with kij=4.
  function automatic longint exp_col(input int mode, input int kij, input int n, input int j, input int obw);
    longint v;
    case (mode)
      0:       v = n + j;
      1:       v = kij;
      2:       v = -3 * kij;
      3:       if (obw == 20) v = (n == 0) ? 131068 : -131072;
               else           v = (n == 0) ? 65535 : -65536;
      default: v = kij * n;
    endcase
`ifdef SFU_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  function automatic logic [191:0] exp_vec(input int mode, input int kij, input int n, input int obw);
    logic [191:0] r;
    longint v;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      v = exp_col(mode, kij, n, j, obw);
      if (obw == 20) r[j*20 +: 20] = v[19:0];
      else           r[j*17 +: 17] = v[16:0];
    end
    return r;
  endfunction

  task automatic start_job(input int kij, input int nij);
    start   = 1'b1;
    cfg_kij = 4'(kij);
    cfg_nij = 6'(nij);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int mode, input int kij, input int nij);
    for (int k = 0; k < kij; k++) begin
      for (int n = 0; n < nij; n++) begin
        in_valid = 1'b1;
        in_v     = beat(mode, n);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input int mode, input int kij, input int nij);
    start_job(kij, nij);
    chk("busy_after_start", 192'(busy1), 192'(1));
    chk("in_ready_accum", 192'(in_ready1), 192'(1));
    feed(mode, kij, nij);
  endtask

  task automatic drain(input int mode, input int kij, input int nij, input bit rnd);
    int  k;
    int  cyc;
    bit  acc;
    k   = 0;
    cyc = 0;
    while (k < nij && cyc < 1000) begin
      chk("out_valid", 192'(out_valid1), 192'(1));
      chk($sformatf("out1_beat%0d", k), 192'(out1), exp_vec(mode, kij, k, 20));
      chk($sformatf("out2_beat%0d", k), 192'(out2), exp_vec(mode, kij, k, 17));
      chk($sformatf("out_last_beat%0d", k), 192'(out_last1), 192'(k == nij - 1));
      chk("in_ready_drain", 192'(in_ready1), 192'(0));
      if (rnd) begin
        in_valid  = 1'b1;
        in_v      = '1;
        out_ready = ($urandom_range(0, 2) == 0);
      end else begin
        out_ready = 1'b1;
      end
      acc = out_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) k++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (cyc >= 1000) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed=%0d beats expected=%0d", k, nij);
    end
    chk("done_pulse", 192'(done1), 192'(1));
    chk("done_pulse_obw17", 192'(done2), 192'(1));
    chk("busy_after_drain", 192'(busy1), 192'(0));
    chk("out_zero_idle", 192'(out1), 192'(0));
    @(posedge clk); #1;
    chk("done_one_cycle", 192'(done1), 192'(0));
  endtask

  initial begin
    #12;
    chk("rst_busy", 192'(busy1), 192'(0));
    chk("rst_in_ready", 192'(in_ready1), 192'(0));
    chk("rst_out_valid", 192'(out_valid1), 192'(0));
    chk("rst_out_last", 192'(out_last1), 192'(0));
    chk("rst_done", 192'(done1), 192'(0));
    chk("rst_out", 192'(out1), 192'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single pass, distinct per-column data
    run_job(0, 1, 4);
    drain(0, 1, 4, 1'b0);

    // Full-size jobs, positive then negative
    run_job(1, 9, 36);
    drain(1, 9, 36, 1'b0);
    run_job(2, 9, 36);
    drain(2, 9, 36, 1'b0);

    // Saturation at both rails
    run_job(3, 4, 2);
    drain(3, 4, 2, 1'b0);

    // Random backpressure with junk input during drain
    run_job(4, 2, 36);
    drain(4, 2, 36, 1'b1);

    // Async reset mid-accumulation
    start_job(9, 4);
    feed(0, 4, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 192'(busy1), 192'(0));
    chk("async_rst_in_ready", 192'(in_ready1), 192'(0));
    chk("async_rst_out_valid", 192'(out_valid1), 192'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_job(0, 1, 4);
    drain(0, 1, 4, 1'b0);

    // Out-of-range configurations are ignored
    start_job(1, 0);
    chk("bad_nij_busy", 192'(busy1), 192'(0));
    chk("bad_nij_in_ready", 192'(in_ready1), 192'(0));
    start_job(10, 4);
    chk("bad_kij_busy", 192'(busy1), 192'(0));
    chk("bad_kij_in_ready", 192'(in_ready1), 192'(0));
    @(posedge clk); #1;
    chk("bad_cfg_still_idle", 192'(busy1), 192'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
